// File: rtl/async_arbiter_client.sv
// async_arbiter_client: core-clock front end driving a 4-phase req/ack handshake on one arbiter leaf (release port is release_pulse)
module async_arbiter_client #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_W      = 16,
    parameter int MAX_HOLD    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acquire,
    input  logic              release_pulse,
    output logic              granted,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              overrun,
    output logic              req,
    input  logic              ack
);
    typedef enum logic [1:0] {IDLE, REQ, HELD, REL} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic ack_s, pend, pend_n, rel_pend, rel_pend_n, over_q, over_n, hit, req_n;
    logic [HOLD_W-1:0] cnt_n;
    assign ack_s   = sync[SYNC_STAGES-1];
    assign busy    = (state != IDLE) || pend;
    assign req_n   = (state_n == REQ) || (state_n == HELD);
    assign hit     = (MAX_HOLD != 0) && (state == HELD) && (hold_cnt == HOLD_W'(MAX_HOLD));
    assign overrun = over_q | hit;
    assign cnt_n   = (state == REQ && state_n == HELD) ? '0 :
                     (state == HELD && hold_cnt != '1) ? hold_cnt + HOLD_W'(1) : hold_cnt;
    assign over_n  = (state == IDLE && state_n == REQ) ? 1'b0 : over_q | hit;
    // ack synchroniser: the only place the asynchronous ack is sampled
    always_ff @(posedge clk or posedge reset)
        if (reset)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], ack};
    // handshake sequencing and pending acquire/release bookkeeping
    always_comb begin
        state_n    = state;
        pend_n     = pend;
        rel_pend_n = rel_pend;
        case (state)
            IDLE:
                if (ack_s)
                    pend_n = pend | acquire;
                else if (pend | acquire) begin
                    state_n = REQ;
                    pend_n  = 1'b0;
                end
            REQ: begin
                rel_pend_n = rel_pend | release_pulse;
                if (ack_s)
                    state_n = rel_pend_n ? REL : HELD;
            end
            HELD:
                if (release_pulse)
                    state_n = REL;
            default:
                if (!ack_s) begin
                    state_n    = IDLE;
                    rel_pend_n = 1'b0;
                end
        endcase
    end
    // state plus registered req/granted so the leaf never sees a combinational glitch
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            pend     <= 1'b0;
            rel_pend <= 1'b0;
            req      <= 1'b0;
            granted  <= 1'b0;
            hold_cnt <= '0;
            over_q   <= 1'b0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            rel_pend <= rel_pend_n;
            req      <= req_n;
            granted  <= state_n == HELD;
            hold_cnt <= cnt_n;
            over_q   <= over_n;
        end
    // 4-phase rule: req rises only with ack_s low and never drops while REQ still waits for ack_s
    a_rise: assert property (@(posedge clk) disable iff (reset) !(!req && req_n && ack_s));
    a_fall: assert property (@(posedge clk) disable iff (reset) !(req && !req_n && state == REQ && !ack_s));
endmodule
